// File: rtl/sram_fifo.sv
// Show-ahead synchronous FIFO built on a 1R1W SRAM whose registered read port is
// kept pointed at the head, so dequeue_value shows the oldest entry without a pop.

module sram_1r1w #(
    parameter int WIDTH             = 32,
    parameter int DEPTH             = 64,
    parameter int ADDR_WIDTH        = $clog2(DEPTH),
    parameter     READ_DURING_WRITE = "NEW_DATA"
) (
    input  logic                  clk,
    input  logic                  read_en,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    output logic [WIDTH-1:0]      read_data,
    input  logic                  write_en,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [WIDTH-1:0]      write_data
);
    localparam bit NEW_DATA_MODE = (READ_DURING_WRITE == "NEW_DATA");

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_read_data;

    always_ff @(posedge clk) begin
        if (write_en) begin
            r_mem[write_addr] <= write_data;
        end
        if (read_en) begin
            // Same-address collision returns the word being written this edge.
            if (NEW_DATA_MODE && write_en && (write_addr == read_addr)) begin
                r_read_data <= write_data;
            end else begin
                r_read_data <= r_mem[read_addr];
            end
        end
    end

    assign read_data = r_read_data;
endmodule

module sram_fifo #(
    parameter int WIDTH                 = 32,
    parameter int SIZE                  = 64,
    parameter int ALMOST_FULL_THRESHOLD = SIZE - 4,
    parameter int ADDR_WIDTH            = $clog2(SIZE),
    parameter bit ILLEGAL_OP_ASSERT     = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  enqueue_en,
    input  logic [WIDTH-1:0]      enqueue_value,
    output logic                  full,
    output logic                  almost_full,
    input  logic                  dequeue_en,
    output logic [WIDTH-1:0]      dequeue_value,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count
);
    localparam logic [ADDR_WIDTH:0] SIZE_C = (ADDR_WIDTH + 1)'(SIZE);
    localparam logic [ADDR_WIDTH:0] AF_C   = (ADDR_WIDTH + 1)'(ALMOST_FULL_THRESHOLD);

    logic [ADDR_WIDTH-1:0] r_read_ptr;
    logic [ADDR_WIDTH-1:0] r_write_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_full;
    logic                  r_almost_full;
    logic                  r_empty;

    logic                  w_enq_ok;
    logic                  w_deq_ok;
    logic [ADDR_WIDTH:0]   w_count_next;
    logic [ADDR_WIDTH-1:0] w_read_addr;
    logic [WIDTH-1:0]      w_read_data;

    // Flush wins over both ports, so gate them here rather than in the state update.
    assign w_enq_ok = enqueue_en & ~r_full  & ~flush;
    assign w_deq_ok = dequeue_en & ~r_empty & ~flush;

    // Look one entry ahead on a pop so the next head lands on read_data a cycle later.
    assign w_read_addr = w_deq_ok ? (r_read_ptr + 1'b1) : r_read_ptr;

    always_comb begin
        w_count_next = r_count;
        if (w_enq_ok && !w_deq_ok) begin
            w_count_next = r_count + 1'b1;
        end else if (!w_enq_ok && w_deq_ok) begin
            w_count_next = r_count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_read_ptr    <= '0;
            r_write_ptr   <= '0;
            r_count       <= '0;
            r_empty       <= 1'b1;
            r_full        <= 1'b0;
            r_almost_full <= 1'b0;
        end else if (flush) begin
            r_read_ptr    <= '0;
            r_write_ptr   <= '0;
            r_count       <= '0;
            r_empty       <= 1'b1;
            r_full        <= 1'b0;
            r_almost_full <= 1'b0;
        end else begin
            if (w_enq_ok) begin
                r_write_ptr <= r_write_ptr + 1'b1;
            end
            if (w_deq_ok) begin
                r_read_ptr <= r_read_ptr + 1'b1;
            end
            r_count       <= w_count_next;
            r_empty       <= (w_count_next == '0);
            r_full        <= (w_count_next == SIZE_C);
            r_almost_full <= (w_count_next >= AF_C);
        end
    end

    sram_1r1w #(
        .WIDTH             (WIDTH),
        .DEPTH             (SIZE),
        .ADDR_WIDTH        (ADDR_WIDTH),
        .READ_DURING_WRITE ("NEW_DATA")
    ) u_sram (
        .clk        (clk),
        .read_en    (1'b1),
        .read_addr  (w_read_addr),
        .read_data  (w_read_data),
        .write_en   (w_enq_ok),
        .write_addr (r_write_ptr),
        .write_data (enqueue_value)
    );

    assign dequeue_value = w_read_data;
    assign full          = r_full;
    assign almost_full   = r_almost_full;
    assign empty         = r_empty;
    assign count         = r_count;

    generate
        if (ILLEGAL_OP_ASSERT) begin : g_illegal_op_check
            a_enq_while_full: assert property (@(posedge clk) disable iff (!reset)
                !(enqueue_en && r_full && !flush))
                else $error("sram_fifo: enqueue while full dropped");
            a_deq_while_empty: assert property (@(posedge clk) disable iff (!reset)
                !(dequeue_en && r_empty && !flush))
                else $error("sram_fifo: dequeue while empty ignored");
        end
    endgenerate
endmodule

// File: tb/tb_sram_fifo.sv
// Randomized bench for sram_fifo, checked every cycle against a queue-based
// model of an ideal show-ahead FIFO.

module tb_sram_fifo;
    localparam int WIDTH = 32;
    localparam int SIZE  = 8;
    localparam int THR   = 6;
    localparam int AW    = $clog2(SIZE);

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             flush = 1'b0;
    logic             enqueue_en = 1'b0;
    logic [WIDTH-1:0] enqueue_value = '0;
    logic             full;
    logic             almost_full;
    logic             dequeue_en = 1'b0;
    logic [WIDTH-1:0] dequeue_value;
    logic             empty;
    logic [AW:0]      count;

    int checks_run = 0;
    int fail_count = 0;
    logic [WIDTH-1:0] model_q[$];

    sram_fifo #(
        .WIDTH                 (WIDTH),
        .SIZE                  (SIZE),
        .ALMOST_FULL_THRESHOLD (THR),
        .ILLEGAL_OP_ASSERT     (1'b0)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .enqueue_en    (enqueue_en),
        .enqueue_value (enqueue_value),
        .full          (full),
        .almost_full   (almost_full),
        .dequeue_en    (dequeue_en),
        .dequeue_value (dequeue_value),
        .empty         (empty),
        .count         (count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_run++;
        if (got !== exp) begin
            fail_count++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Compare every output against the model's view of the queue.
    task automatic check_state(input string tag);
        check_eq({tag, ".count"}, 64'(count), 64'(model_q.size()));
        check_eq({tag, ".empty"}, 64'(empty), 64'(model_q.size() == 0));
        check_eq({tag, ".full"}, 64'(full), 64'(model_q.size() == SIZE));
        check_eq({tag, ".almost_full"}, 64'(almost_full), 64'(model_q.size() >= THR));
        if (model_q.size() != 0) begin
            check_eq({tag, ".head"}, 64'(dequeue_value), 64'(model_q[0]));
        end
    endtask

    // One clock: drive, let the edge happen, update the model, sample 1 time unit later.
    task automatic step(input logic enq, input logic [WIDTH-1:0] val, input logic deq,
                        input logic fl, input string tag);
        bit can_enq, can_deq;
        enqueue_en    = enq;
        enqueue_value = val;
        dequeue_en    = deq;
        flush         = fl;
        can_enq = enq && (model_q.size() < SIZE);
        can_deq = deq && (model_q.size() > 0);
        @(posedge clk);
        if (fl) begin
            model_q.delete();
        end else begin
            if (can_deq) void'(model_q.pop_front());
            if (can_enq) model_q.push_back(val);
        end
        #1;
        enqueue_en = 1'b0;
        dequeue_en = 1'b0;
        flush      = 1'b0;
        $display("cyc %s enq=%0d val=0x%0h deq=%0d flush=%0d -> count=%0d head=0x%0h",
                 tag, enq, val, deq, fl, count, dequeue_value);
        check_state(tag);
    endtask

    task automatic fill(input int n, input logic [WIDTH-1:0] base);
        for (int i = 0; i < n; i++) step(1'b1, base + WIDTH'(i), 1'b0, 1'b0, "fill");
    endtask

    initial begin
        int sent, recv, cycles;
        logic e, d;

        // Reset state
        reset = 1'b0;
        #12;
        check_state("reset");
        @(posedge clk);
        #1;
        reset = 1'b1;
        check_state("reset_rel");

        // 1: single enqueue is visible next cycle
        step(1'b1, 32'hA5A5_0001, 1'b0, 1'b0, "t1_enq");
        check_eq("t1.head_const", 64'(dequeue_value), 64'h0000_0000_A5A5_0001);
        step(1'b0, '0, 1'b1, 1'b0, "t1_deq");

        // 2: fill, overflow drop, drain in order
        for (int i = 0; i < SIZE; i++) begin
            step(1'b1, WIDTH'(i), 1'b0, 1'b0, "t2_enq");
            check_eq("t2.af_edge", 64'(almost_full), 64'(i >= THR - 1));
        end
        check_eq("t2.full", 64'(full), 64'd1);
        step(1'b1, 32'hDEAD, 1'b1 & 1'b0, 1'b0, "t2_ovf");
        step(1'b1, 32'hDEAD, 1'b1, 1'b0, "t2_ovf_deq");
        for (int i = 1; i < SIZE; i++) begin
            check_eq("t2.order", 64'(dequeue_value), 64'(i));
            step(1'b0, '0, 1'b1, 1'b0, "t2_deq");
        end
        check_eq("t2.empty", 64'(empty), 64'd1);
        step(1'b0, '0, 1'b1, 1'b0, "t2_underflow");

        // 3: bypass with count==1
        step(1'b1, 32'h11, 1'b0, 1'b0, "t3_enq");
        step(1'b1, 32'h22, 1'b1, 1'b0, "t3_byp");
        check_eq("t3.bypass_head", 64'(dequeue_value), 64'h22);
        check_eq("t3.count", 64'(count), 64'd1);
        step(1'b0, '0, 1'b1, 1'b0, "t3_deq");

        // 4: random stream across pointer wrap
        sent = 0;
        recv = 0;
        cycles = 0;
        while (recv < 20 && cycles < 2000) begin
            e = (sent < 20) && ($urandom_range(0, 3) != 0);
            d = ($urandom_range(0, 2) != 0);
            if (d && !empty) begin
                check_eq("t4.order", 64'(dequeue_value), 64'(32'h100 + recv));
                recv++;
            end
            if (e && !full) sent++;
            step(e, 32'h100 + WIDTH'(sent - ((e && !full) ? 1 : 0)), d, 1'b0, "t4");
            check_eq("t4.count_le_size", 64'(count <= SIZE), 64'd1);
            cycles++;
        end
        check_eq("t4.all_received", 64'(recv), 64'd20);

        // 5: flush beats same-cycle enqueue/dequeue
        fill(5, 32'h500);
        step(1'b1, 32'h77, 1'b1, 1'b1, "t5_flush");
        check_eq("t5.count", 64'(count), 64'd0);
        step(1'b1, 32'h88, 1'b0, 1'b0, "t5_enq");
        check_eq("t5.no_77", 64'(dequeue_value), 64'h88);
        step(1'b0, '0, 1'b1, 1'b0, "t5_deq");

        // 6: asynchronous reset mid-cycle
        fill(5, 32'h600);
        #2;
        reset = 1'b0;
        #1;
        model_q.delete();
        check_state("t6_async");
        check_eq("t6.count_now", 64'(count), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        step(1'b1, 32'hA5A5_0001, 1'b0, 1'b0, "t6_enq");
        check_eq("t6.head", 64'(dequeue_value), 64'h0000_0000_A5A5_0001);
        step(1'b0, '0, 1'b1, 1'b0, "t6_deq");

        $display("TB_RESULT checks=%0d failures=%0d", checks_run, fail_count);
        $finish;
    end
endmodule
